// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store unit: access sizes and controller states.
package lsu_pkg;

  // Access size encoding, shared by the pipeline request and the memory load_type.
  localparam logic [1:0] SZ_WORD = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_BYTE = 2'b10;
  localparam logic [1:0] SZ_INV  = 2'b11;

  // Controller states.
  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    LOAD  = 2'b01,
    STORE = 2'b10,
    RESP  = 2'b11
  } lsu_state_t;

endpackage

// File: rtl/lsu_load_extend.sv
// Final sign/zero extension of load data. The memory already extends, but signed
// half/byte results are re-extended here so the result never depends on it.
module lsu_load_extend
  import lsu_pkg::*;
(
  input  logic [31:0] i_rdata,
  input  logic [1:0]  i_size,
  input  logic        i_unsigned,
  output logic [31:0] o_data
);

  // Select the extension from the captured size and signedness.
  always_comb begin
    o_data = i_rdata;
    case (i_size)
      SZ_HALF: o_data = i_unsigned ? {16'b0, i_rdata[15:0]}
                                   : {{16{i_rdata[15]}}, i_rdata[15:0]};
      SZ_BYTE: o_data = i_unsigned ? {24'b0, i_rdata[7:0]}
                                   : {{24{i_rdata[7]}}, i_rdata[7:0]};
      default: o_data = i_rdata;
    endcase
  end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store initiator between the MEM stage and data memory. One request at a
// time; all pipeline-facing and memory-facing outputs are registered.
module lsu_ctrl
  import lsu_pkg::*;
#(
  parameter int RD_LATENCY = 2,   // cycles the read request is held; must be >= 1
  parameter int MEM_ADDR_W = 14   // implemented byte-address bits
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic        resp_err,
  output logic [31:0] resp_rdata,
  output logic        mem_read,
  output logic        mem_write,
  output logic [1:0]  mem_load_type,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  localparam int CNT_W = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RD_LATENCY - 1);

  lsu_state_t       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [1:0]       r_size;
  logic             r_unsigned;
  logic             r_req_ready;
  logic             r_resp_valid;
  logic             r_resp_err;
  logic [31:0]      r_resp_rdata;
  logic             r_mem_read;
  logic             r_mem_write;
  logic [1:0]       r_mem_load_type;
  logic [31:0]      r_mem_addr;
  logic [31:0]      r_mem_wdata;

  logic [31:0] w_addr_hi;
  logic        w_err;
  logic        w_accept;
  logic [31:0] w_ext_data;

  // Request validity: bad size, misalignment, or address beyond the implemented range.
  assign w_addr_hi = req_addr >> MEM_ADDR_W;
  assign w_err     = (req_size == SZ_INV)
                  || ((req_size == SZ_WORD) && (req_addr[1:0] != 2'b00))
                  || ((req_size == SZ_HALF) && req_addr[0])
                  || (w_addr_hi != 32'b0);
  assign w_accept  = req_valid && r_req_ready;

  lsu_load_extend u_extend (
    .i_rdata    (mem_rdata),
    .i_size     (r_size),
    .i_unsigned (r_unsigned),
    .o_data     (w_ext_data)
  );

  // Controller FSM with registered outputs; the mem_* registers double as the
  // captured request so they stay stable for the whole access.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state         <= IDLE;
      r_cnt           <= '0;
      r_size          <= SZ_WORD;
      r_unsigned      <= 1'b0;
      r_req_ready     <= 1'b1;
      r_resp_valid    <= 1'b0;
      r_resp_err      <= 1'b0;
      r_resp_rdata    <= 32'b0;
      r_mem_read      <= 1'b0;
      r_mem_write     <= 1'b0;
      r_mem_load_type <= 2'b00;
      r_mem_addr      <= 32'b0;
      r_mem_wdata     <= 32'b0;
    end else begin
      // Response is a single-cycle pulse unless a state below raises it.
      r_resp_valid <= 1'b0;
      r_resp_err   <= 1'b0;
      r_resp_rdata <= 32'b0;
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_req_ready <= 1'b0;
            r_size      <= req_size;
            r_unsigned  <= req_unsigned;
            r_cnt       <= '0;
            if (w_err) begin
              // Rejected requests never touch memory.
              r_state      <= RESP;
              r_resp_valid <= 1'b1;
              r_resp_err   <= 1'b1;
            end else begin
              r_mem_load_type <= req_size;
              r_mem_addr      <= req_addr;
              r_mem_wdata     <= req_wdata;
              if (req_we) begin
                r_mem_write <= 1'b1;
                r_state     <= STORE;
              end else begin
                r_mem_read <= 1'b1;
                r_state    <= LOAD;
              end
            end
          end
        end
        LOAD: begin
          if (r_cnt == CNT_LAST) begin
            r_mem_read      <= 1'b0;
            r_mem_load_type <= 2'b00;
            r_mem_addr      <= 32'b0;
            r_mem_wdata     <= 32'b0;
            r_resp_valid    <= 1'b1;
            r_resp_rdata    <= w_ext_data;
            r_state         <= RESP;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        STORE: begin
          r_mem_write     <= 1'b0;
          r_mem_load_type <= 2'b00;
          r_mem_addr      <= 32'b0;
          r_mem_wdata     <= 32'b0;
          r_resp_valid    <= 1'b1;
          r_state         <= RESP;
        end
        default: begin
          // RESP: pulse already on the outputs; reopen for the next request.
          r_req_ready <= 1'b1;
          r_state     <= IDLE;
        end
      endcase
    end
  end

  assign req_ready     = r_req_ready;
  assign resp_valid    = r_resp_valid;
  assign resp_err      = r_resp_err;
  assign resp_rdata    = r_resp_rdata;
  assign mem_read      = r_mem_read;
  assign mem_write     = r_mem_write;
  assign mem_load_type = r_mem_load_type;
  assign mem_addr      = r_mem_addr;
  assign mem_wdata     = r_mem_wdata;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Testbench for lsu_ctrl: directed cases plus randomized requests checked
// cycle by cycle against a transaction-level reference model.
module tb_lsu_ctrl;

  localparam int RDL = 2;
  localparam int AW  = 14;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_err;
  logic [31:0] resp_rdata;
  logic        mem_read;
  logic        mem_write;
  logic [1:0]  mem_load_type;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  lsu_ctrl #(.RD_LATENCY(RDL), .MEM_ADDR_W(AW)) dut (
    .clk           (clk),
    .rst           (rst),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_we        (req_we),
    .req_size      (req_size),
    .req_unsigned  (req_unsigned),
    .req_addr      (req_addr),
    .req_wdata     (req_wdata),
    .resp_valid    (resp_valid),
    .resp_err      (resp_err),
    .resp_rdata    (resp_rdata),
    .mem_read      (mem_read),
    .mem_write     (mem_write),
    .mem_load_type (mem_load_type),
    .mem_addr      (mem_addr),
    .mem_wdata     (mem_wdata),
    .mem_rdata     (mem_rdata)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: is the request illegal?
  function automatic bit model_err(input logic [1:0] sz, input logic [31:0] a);
    longint ua;
    ua = longint'(a);
    if (sz == 2'd3) return 1'b1;
    if (sz == 2'd0 && (ua % 4) != 0) return 1'b1;
    if (sz == 2'd1 && (ua % 2) != 0) return 1'b1;
    if (ua >= (longint'(1) << AW)) return 1'b1;
    return 1'b0;
  endfunction

  // Reference: value the pipeline should see for a load.
  function automatic logic [31:0] model_load(input logic [1:0] sz, input bit uns,
                                             input logic [31:0] rd);
    longint v;
    longint m;
    if (sz == 2'd0) return rd;
    m = (sz == 2'd1) ? 65536 : 256;
    v = longint'(rd) % m;
    if (!uns && v >= m / 2) v = v - m;
    return v[31:0];
  endfunction

  // One complete transaction, started at a negedge with the unit idle.
  // hold keeps req_valid high (with junk fields) while the unit is busy.
  task automatic run_txn(input bit we, input logic [1:0] sz, input bit uns,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [31:0] rd, input bit hold);
    bit          err;
    int          busy;
    logic [31:0] exp_rdata;
    err       = model_err(sz, addr);
    busy      = err ? 0 : (we ? 1 : RDL);
    exp_rdata = (err || we) ? 32'b0 : model_load(sz, uns, rd);

    chk("ready_before_accept", {31'b0, req_ready}, 32'd1);
    req_valid    = 1'b1;
    req_we       = we;
    req_size     = sz;
    req_unsigned = uns;
    req_addr     = addr;
    req_wdata    = wdata;
    @(posedge clk);
    @(negedge clk);
    req_valid    = hold;
    req_we       = 1'($urandom);
    req_size     = 2'($urandom);
    req_unsigned = 1'($urandom);
    req_addr     = $urandom;
    req_wdata    = $urandom;

    for (int i = 0; i < busy; i++) begin
      chk("busy_ready", {31'b0, req_ready}, 32'd0);
      chk("busy_resp_valid", {31'b0, resp_valid}, 32'd0);
      chk("busy_mem_read", {31'b0, mem_read}, {31'b0, !we});
      chk("busy_mem_write", {31'b0, mem_write}, {31'b0, we});
      chk("busy_mem_addr", mem_addr, addr);
      chk("busy_mem_type", {30'b0, mem_load_type}, {30'b0, sz});
      chk("busy_mem_wdata", mem_wdata, wdata);
      mem_rdata = (i == busy - 1) ? rd : $urandom;
      @(negedge clk);
    end

    chk("resp_valid", {31'b0, resp_valid}, 32'd1);
    chk("resp_err", {31'b0, resp_err}, {31'b0, err});
    chk("resp_rdata", resp_rdata, exp_rdata);
    chk("resp_ready", {31'b0, req_ready}, 32'd0);
    chk("resp_mem_read", {31'b0, mem_read}, 32'd0);
    chk("resp_mem_write", {31'b0, mem_write}, 32'd0);
    chk("resp_mem_addr", mem_addr, 32'd0);
    chk("resp_mem_wdata", mem_wdata, 32'd0);
    mem_rdata = $urandom;
    @(negedge clk);

    chk("after_resp_valid", {31'b0, resp_valid}, 32'd0);
    chk("after_resp_err", {31'b0, resp_err}, 32'd0);
    chk("after_resp_rdata", resp_rdata, 32'd0);
    $display("txn we=%0d size=%0d uns=%0d addr=%h wdata=%h rd=%h -> err=%0d rdata=%h hold=%0d",
             we, sz, uns, addr, wdata, rd, err, exp_rdata, hold);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit          we;
    logic [1:0]  sz;
    bit          uns;
    logic [31:0] addr;
    bit          hold;

    rst          = 1'b1;
    req_valid    = 1'b0;
    req_we       = 1'b0;
    req_size     = 2'b00;
    req_unsigned = 1'b0;
    req_addr     = 32'b0;
    req_wdata    = 32'b0;
    mem_rdata    = 32'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", {31'b0, req_ready}, 32'd1);
    chk("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
    chk("rst_resp_err", {31'b0, resp_err}, 32'd0);
    chk("rst_resp_rdata", resp_rdata, 32'd0);
    chk("rst_mem_read", {31'b0, mem_read}, 32'd0);
    chk("rst_mem_write", {31'b0, mem_write}, 32'd0);
    chk("rst_mem_type", {30'b0, mem_load_type}, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Directed cases.
    run_txn(1'b0, 2'b10, 1'b0, 32'h0000_0103, 32'h0, 32'hFFFF_FF80, 1'b0);
    run_txn(1'b0, 2'b01, 1'b1, 32'h0000_0202, 32'h0, 32'hFFFF_8001, 1'b0);
    run_txn(1'b1, 2'b00, 1'b0, 32'h0000_0010, 32'hDEAD_BEEF, 32'h1234_5678, 1'b0);
    run_txn(1'b0, 2'b00, 1'b0, 32'h0000_0006, 32'h0, 32'hAAAA_5555, 1'b0);
    run_txn(1'b0, 2'b00, 1'b0, 32'h0000_4000, 32'h0, 32'hAAAA_5555, 1'b0);
    run_txn(1'b1, 2'b11, 1'b0, 32'h0000_0020, 32'h0BAD_F00D, 32'h0, 1'b0);
    run_txn(1'b0, 2'b00, 1'b0, 32'h0000_3FFC, 32'h0, 32'h8765_4321, 1'b0);
    run_txn(1'b0, 2'b01, 1'b0, 32'h0000_0101, 32'h0, 32'h0, 1'b0);
    run_txn(1'b0, 2'b10, 1'b1, 32'h0000_0007, 32'h0, 32'h1234_56F0, 1'b0);
    run_txn(1'b0, 2'b01, 1'b0, 32'h0000_0102, 32'h0, 32'h0000_9234, 1'b0);

    // Back-to-back with req_valid held high throughout.
    run_txn(1'b0, 2'b00, 1'b0, 32'h0000_0040, 32'h0, 32'hCAFE_0001, 1'b1);
    run_txn(1'b1, 2'b10, 1'b0, 32'h0000_0041, 32'h0000_00A5, 32'h0, 1'b1);
    run_txn(1'b0, 2'b00, 1'b0, 32'h0000_0042, 32'h0, 32'h0, 1'b1);
    run_txn(1'b0, 2'b10, 1'b0, 32'h0000_0043, 32'h0, 32'h0000_007F, 1'b0);

    // Reset during the first LOAD cycle aborts the access.
    req_valid = 1'b1;
    req_we    = 1'b0;
    req_size  = 2'b00;
    req_addr  = 32'h0000_0100;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    chk("abort_mem_read_before", {31'b0, mem_read}, 32'd1);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("abort_mem_read", {31'b0, mem_read}, 32'd0);
    chk("abort_mem_addr", mem_addr, 32'd0);
    chk("abort_ready", {31'b0, req_ready}, 32'd1);
    for (int i = 0; i < 5; i++) begin
      chk("abort_no_resp", {31'b0, resp_valid}, 32'd0);
      chk("abort_no_read", {31'b0, mem_read}, 32'd0);
      @(negedge clk);
    end

    // Randomized requests against the reference model.
    for (int n = 0; n < 60; n++) begin
      we  = 1'($urandom);
      sz  = 2'($urandom);
      uns = 1'($urandom);
      if ($urandom_range(0, 7) == 0) addr = $urandom;
      else addr = $urandom_range(0, (1 << AW) - 1);
      if ($urandom_range(0, 1) == 1) addr = addr & 32'hFFFF_FFFC;
      hold = (n == 59) ? 1'b0 : 1'($urandom);
      run_txn(we, sz, uns, addr, $urandom, $urandom, hold);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/lsu_ctrl.md
Name: lsu_ctrl

Overview:
- Load/store initiator between the CPU pipeline's MEM stage and the data memory.
- Accepts one pipeline request at a time and checks alignment and range.
- Drives the memory's MemRead/MemWrite/load_type/addr/din interface, holding it stable for the memory's read latency.
- Returns a single-cycle response to the pipeline: load data with final sign or zero extension, or an error flag.

Parameters:
- RD_LATENCY, 2: cycles the memory request must be held before mem_rdata is valid; minimum 1.
- MEM_ADDR_W, 14: implemented address bits. Any request with req_addr[31:MEM_ADDR_W] != 0 is out of range.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  pipeline request present.
- req_ready  out  1  lsu can accept a request (IDLE only).
- req_we  in  1  1 = store, 0 = load.
- req_size  in  2  00 word, 01 half, 10 byte, 11 invalid.
- req_unsigned  in  1  zero-extend half/byte loads (lhu/lbu).
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-aligned.
- resp_valid  out  1  one-cycle response pulse.
- resp_err  out  1  misaligned, invalid size, or out of range; valid with resp_valid.
- resp_rdata  out  32  extended load data; 0 for stores and errors.
- mem_read  out  1  to memory MemRead.
- mem_write  out  1  to memory MemWrite.
- mem_load_type  out  2  to memory load_type; same encoding as req_size.
- mem_addr  out  32  to memory addr.
- mem_wdata  out  32  to memory din.
- mem_rdata  in  32  memory dout; already sign-extended per load_type.

Behaviour:
- Reset, checked on posedge with rst=1:
  - state=IDLE, req_ready=1, resp_valid=0, resp_err=0, resp_rdata=0.
  - mem_read=0, mem_write=0, mem_load_type=0, mem_addr=0, mem_wdata=0.
  - Reset mid-operation aborts the access. No response is ever produced for the aborted request, and memory strobes drop in the following cycle.
- States: IDLE, LOAD, STORE, RESP.
- Acceptance: a request is accepted on a posedge where req_valid & req_ready. The lsu registers we, size, unsigned, addr and wdata; pipeline inputs are ignored afterwards.
- Error check at acceptance; an error occurs when any of the following holds:
  - size==11;
  - word with addr[1:0]!=0;
  - half with addr[0]!=0;
  - addr[31:MEM_ADDR_W]!=0.
- Error path:
  - Next state RESP with resp_err=1, resp_rdata=0.
  - No memory strobe is asserted.
  - Latency is 1 cycle from the acceptance edge.
- LOAD:
  - mem_read=1; mem_load_type, mem_addr and mem_wdata are driven from the captured registers and held constant.
  - A counter runs 0..RD_LATENCY-1. On the posedge ending the cycle where counter==RD_LATENCY-1, mem_rdata is sampled and the state moves to RESP.
  - Extension rules:
    - word: passes through unchanged;
    - half unsigned: {16'b0, rdata[15:0]};
    - byte unsigned: {24'b0, rdata[7:0]};
    - half/byte signed: re-sign-extended from bit 15/7, independent of the memory's own extension.
  - Load latency is RD_LATENCY+1 cycles from acceptance to resp_valid.
- STORE:
  - Exactly one cycle with mem_write=1 and addr/type/data held. The memory performs byte-lane replication and enables.
  - Next state RESP, so store latency is 2 cycles.
- RESP:
  - resp_valid=1 for exactly one cycle. There is no response backpressure.
  - req_ready=0; next state IDLE.
  - The next request is accepted at the earliest on the edge ending the IDLE cycle after RESP.
- Outside LOAD/STORE, mem_read=0, mem_write=0, and mem_addr/mem_wdata/mem_load_type=0.
- mem_read and mem_write are never both 1.
- resp_rdata and resp_err are 0 whenever resp_valid=0.

Decomposition:
- Package lsu_pkg:
  - size constants SZ_WORD=2'b00, SZ_HALF=2'b01, SZ_BYTE=2'b10;
  - state encoding IDLE/LOAD/STORE/RESP.
- One sub-module, lsu_load_extend: combinational (rdata, size, unsigned) -> extended word.

Test Plan:
- Signed byte load, req_addr=0x0000_0103, size=10, unsigned=0, mem_rdata=0xFFFF_FF80 -> mem_read held 2 cycles with mem_addr=0x103, mem_load_type=10; resp_valid 3 cycles after accept; resp_rdata=0xFFFF_FF80, resp_err=0.
- Unsigned half load, addr 0x0000_0202, size=01, unsigned=1, mem_rdata=0xFFFF_8001 -> resp_rdata=0x0000_8001.
- Word store, addr 0x0000_0010, wdata 0xDEAD_BEEF -> exactly 1 cycle mem_write=1, mem_wdata=0xDEADBEEF, mem_load_type=00; resp_valid 2 cycles after accept, resp_rdata=0.
- Misaligned word load at addr 0x0000_0006 -> resp_valid next cycle with resp_err=1; mem_read/mem_write never asserted.
- Additional error cases -> resp_err=1:
  - addr 0x0000_4000 with MEM_ADDR_W=14;
  - size=11 store.
- Back-to-back requests with req_valid held high -> req_ready=0 from accept through RESP, second request accepted after the IDLE cycle.
- Reset mid-op: rst asserted during LOAD cycle 1 -> no resp_valid; mem_read=0 from the next cycle.
